// File: rtl/riscv_bus_pkg.sv
// Shared bus constants and the responder state encoding.
// Used by mem_bus_responder and resp_mem_array.
package riscv_bus_pkg;

    localparam int XLEN  = 32;
    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } bus_state_e;

    // True when the word index (addr>>2) does not fit in 2**aw words.
    function automatic logic word_oor(input logic [XLEN-1:0] addr,
                                      input int              aw);
        return (addr >> (aw + 2)) != '0;
    endfunction

endpackage

// File: rtl/resp_mem_array.sv
// Single-port word store: byte-enabled synchronous write, registered read.
// Contents are deliberately not reset.
module resp_mem_array
    import riscv_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   idx,
    input  logic [XLEN-1:0] wdata,
    input  logic [BE_W-1:0] be,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Valid/ready memory responder with WAIT_CYCLES wait states.
// Define MEM_BUS_RESP_ALIGN_CHECK_EN to fault on addr[1:0] != 0.
module mem_bus_responder
    import riscv_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    bus_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic            err_q, err_d;

    logic            req_fault;
    logic            in_idle;
    logic            commit;
    logic            acc_we;
    logic            acc_err;
    logic [AW-1:0]   acc_idx;
    logic [XLEN-1:0] acc_wdata;
    logic [BE_W-1:0] acc_be;
    logic [XLEN-1:0] mem_rdata;

`ifdef MEM_BUS_RESP_ALIGN_CHECK_EN
    assign req_fault = word_oor(req_addr, AW) || (req_addr[1:0] != 2'b00);
`else
    assign req_fault = word_oor(req_addr, AW);
`endif

    // With zero wait states the commit edge is the accept edge,
    // so the array is fed straight from the request port.
    assign in_idle   = (state_q == IDLE);
    assign acc_we    = in_idle ? req_we             : we_q;
    assign acc_err   = in_idle ? req_fault          : err_q;
    assign acc_idx   = in_idle ? req_addr[AW+1:2]   : idx_q;
    assign acc_wdata = in_idle ? req_wdata          : wdata_q;
    assign acc_be    = in_idle ? req_be             : be_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_fault;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    resp_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk   (clk),
        .en    (commit && !acc_err),
        .we    (acc_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (mem_rdata)
    );

    // Response fields derive from held registers, so they stay stable in RESP.
    assign req_ready = in_idle;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? mem_rdata : '0;

endmodule
